// File: rtl/capture_sequencer.sv
// Frame capture sequencer: arms the LVDS image buffer once per line, waits out its
// command latency, drains one line of words and forwards them over valid/ready.
module capture_sequencer #(
    parameter int         PIXELS_PER_LINE = 16,
    parameter int         NUM_LINES       = 8,
    parameter logic [7:0] ARM_CMD         = 8'hA2,
    parameter int         HOLDOFF_CYCLES  = 100,
    parameter int         TIMEOUT_CYCLES  = 40000
) (
    input  logic        clk40M,
    input  logic        nRst,
    input  logic        start,
    input  logic        abort,
    output logic        cmdUpdate,
    output logic [7:0]  cmd,
    input  logic        fifoEmpty,
    output logic        fifoRd,
    input  logic [15:0] fifoData,
    output logic        pixValid,
    output logic [15:0] pixData,
    output logic        pixSof,
    output logic        pixEol,
    input  logic        pixReady,
    output logic        busy,
    output logic        done,
    output logic        timeoutErr,
    output logic [7:0]  lineCount,
    output logic [2:0]  dbgState
);
    localparam int PW = $clog2(PIXELS_PER_LINE);
    localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(PIXELS_PER_LINE - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(NUM_LINES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        HOLDOFF = 3'd2,
        FETCH   = 3'd3,
        LATCH   = 3'd4,
        SEND    = 3'd5
    } stateType;

    stateType      state;
    stateType      nextState;
    logic [PW-1:0] pixCnt;
    logic [LW-1:0] lineCnt;
    logic [HW-1:0] holdCnt;
    logic [TW-1:0] toCnt;
    logic          pixValidQ;
    logic          pixLast;
    logic          lineLast;

    assign pixLast   = (pixCnt == PIX_LAST);
    assign lineLast  = (lineCnt == LINE_LAST);
    assign lineCount = 8'(lineCnt);
    assign dbgState  = state;

    always_ff @(posedge clk40M) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (abort) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) nextState = ARM;
                ARM:     nextState = HOLDOFF;
                HOLDOFF: if (holdCnt == '0) nextState = FETCH;
                FETCH: begin
                    if (!fifoEmpty) begin
                        nextState = LATCH;
                    end else if (toCnt == TO_LAST) begin
                        nextState = IDLE;
                    end
                end
                LATCH:   nextState = SEND;
                SEND: begin
                    if (pixReady) begin
                        if (!pixLast) begin
                            nextState = FETCH;
                        end else if (!lineLast) begin
                            nextState = ARM;
                        end else begin
                            nextState = IDLE;
                        end
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    // pixValid/pixReady: a word transfers on every cycle where both are high; once
    // pixValid is up, pixData/pixSof/pixEol do not change until that cycle. abort
    // withdraws the offer immediately.
    always_comb begin
        cmdUpdate = (state == ARM) && !abort;
        cmd       = cmdUpdate ? ARM_CMD : 8'h00;
        fifoRd    = (state == FETCH) && !fifoEmpty && !abort;
        busy      = (state != IDLE);
        pixValid  = pixValidQ && !abort;
    end

    always_ff @(posedge clk40M) begin
        if (!nRst) begin
            pixCnt     <= '0;
            lineCnt    <= '0;
            holdCnt    <= '0;
            toCnt      <= '0;
            pixValidQ  <= 1'b0;
            pixData    <= '0;
            pixSof     <= 1'b0;
            pixEol     <= 1'b0;
            done       <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                pixValidQ <= 1'b0;
                pixSof    <= 1'b0;
                pixEol    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            lineCnt    <= '0;
                            pixCnt     <= '0;
                            timeoutErr <= 1'b0;
                        end
                    end
                    ARM: holdCnt <= HOLD_LOAD;
                    HOLDOFF: begin
                        if (holdCnt != '0) holdCnt <= holdCnt - 1'b1;
                        toCnt <= '0;
                    end
                    FETCH: begin
                        // A read wins over a timeout that expires on the same cycle.
                        if (fifoEmpty) begin
                            if (toCnt == TO_LAST) begin
                                timeoutErr <= 1'b1;
                            end else begin
                                toCnt <= toCnt + 1'b1;
                            end
                        end
                    end
                    LATCH: begin
                        pixData   <= fifoData;
                        pixValidQ <= 1'b1;
                        pixSof    <= (lineCnt == '0) && (pixCnt == '0);
                        pixEol    <= pixLast;
                    end
                    SEND: begin
                        if (pixReady) begin
                            pixValidQ <= 1'b0;
                            pixSof    <= 1'b0;
                            pixEol    <= 1'b0;
                            if (!pixLast) begin
                                pixCnt <= pixCnt + 1'b1;
                                toCnt  <= '0;
                            end else if (!lineLast) begin
                                lineCnt <= lineCnt + 1'b1;
                                pixCnt  <= '0;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
